pipe_skid_slice: RTL and testbench

Valid/ready register slice that registers both the forward path (valid/data) and the backward path (ready).
It is placed between a producer and a consumer, or around a core inside a synthesis top, to break the long ready combinational path at a block boundary.
It sustains 1 beat/cycle, preserves ordering and never drops or duplicates a beat.
A two-entry buffer (main + skid) absorbs the one-cycle lag of the registered ready.

---
 rtl/pipe_pkg.sv | 17 +
 rtl/pipe_skid_slice.sv | 124 ++++++++++++
 tb/tb_pipe_skid_slice.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and default widths for the valid/ready pipeline slices.
//   slice_state_e : occupancy state of a two-entry register slice
//   DATA_W_DEF    : default payload width, reused by wrapper tops
//   CNT_W_DEF     : default width of delivered-beat debug counters
package pipe_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 16;

  // Encoding equals the number of buffered beats.
  typedef enum logic [1:0] {
    SL_EMPTY = 2'd0,
    SL_ONE   = 2'd1,
    SL_TWO   = 2'd2
  } slice_state_e;

endpackage

// File: rtl/pipe_skid_slice.sv
// Valid/ready register slice with registered forward and backward paths.
// A main register drives m_data; a skid register catches the one beat that
// can arrive while the registered s_ready is still catching up to a stall.
//
// state    | meaning
// ---------+-----------------------------------------------
// SL_EMPTY | nothing buffered; m_valid=0, s_ready=1
// SL_ONE   | main holds the head beat; m_valid=1, s_ready=1
// SL_TWO   | main + skid full; m_valid=1, s_ready=0
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   flush            synchronous clear, top priority
//   s_valid/s_ready/s_data   upstream side (s_ready from state only)
//   m_valid/m_ready/m_data   downstream side (all outputs registered)
//   occ              number of buffered beats, 0..2
//   beat_cnt         count of delivered beats, wraps, survives flush
module pipe_skid_slice
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [1:0]        occ,
  output logic [CNT_W-1:0]  beat_cnt
);

  slice_state_e      r_state;
  slice_state_e      w_state_nxt;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic [CNT_W-1:0]  r_cnt;

  logic w_s_fire;
  logic w_m_fire;
  logic w_load_main_s;
  logic w_load_main_skid;
  logic w_load_skid;

  // Outputs are pure decodes of the state flops, so m_ready never reaches
  // s_ready combinationally.
  assign m_valid  = (r_state != SL_EMPTY);
  assign s_ready  = (r_state != SL_TWO);
  assign m_data   = r_main;
  assign occ      = r_state;
  assign beat_cnt = r_cnt;

  assign w_s_fire = s_valid && s_ready;
  assign w_m_fire = m_valid && m_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_s    = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush) begin
      w_state_nxt = SL_EMPTY;
    end else begin
      unique case (r_state)
        SL_EMPTY: begin
          if (w_s_fire) begin
            w_load_main_s = 1'b1;
            w_state_nxt   = SL_ONE;
          end
        end
        SL_ONE: begin
          if (w_s_fire && w_m_fire) begin
            w_load_main_s = 1'b1;
          end else if (w_s_fire) begin
            w_load_skid = 1'b1;
            w_state_nxt = SL_TWO;
          end else if (w_m_fire) begin
            w_state_nxt = SL_EMPTY;
          end
        end
        SL_TWO: begin
          if (w_m_fire) begin
            w_load_main_skid = 1'b1;
            w_state_nxt      = SL_ONE;
          end
        end
        default: w_state_nxt = SL_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SL_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_main_s) r_main <= s_data;
      else if (w_load_main_skid) r_main <= r_skid;
      if (w_load_skid) r_skid <= s_data;
    end
  end

  // Counts deliveries even in a flush cycle: the beat did leave the slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else if (w_m_fire) r_cnt <= r_cnt + 1'b1;
  end

  a_no_sfire_in_two: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_s_fire && r_state == SL_TWO));

  a_mdata_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (m_valid && !m_ready && !flush) |=> (m_data == $past(m_data)));

  a_occ_matches: assert property (@(posedge clk) disable iff (!rst_n)
    occ == ({1'b0, m_valid} + {1'b0, !s_ready}));

endmodule

// File: tb/tb_pipe_skid_slice.sv
module tb_pipe_skid_slice;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        m_ready = 1'b0;
  logic        s_ready, m_valid;
  logic [7:0]  m_data;
  logic [1:0]  occ;
  logic [15:0] beat_cnt;
  logic        s_ready4, m_valid4;
  logic [7:0]  m_data4;
  logic [1:0]  occ4;
  logic [3:0]  beat_cnt4;

  int errors = 0;
  int checks = 0;
  logic [7:0] q[$];
  int exp_cnt = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  pipe_skid_slice #(.DATA_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .occ(occ), .beat_cnt(beat_cnt));

  pipe_skid_slice #(.DATA_W(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready4), .s_data(s_data),
    .m_valid(m_valid4), .m_ready(m_ready), .m_data(m_data4),
    .occ(occ4), .beat_cnt(beat_cnt4));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: the queue holds exactly the beats the slice should hold.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      exp_cnt = 0;
    end else if (mon_en) begin
      chk("occ", {30'd0, occ}, q.size());
      chk("m_valid", {31'd0, m_valid}, {31'd0, q.size() != 0});
      chk("s_ready", {31'd0, s_ready}, {31'd0, q.size() < 2});
      chk("occ4", {30'd0, occ4}, q.size());
      if (m_valid && m_ready) begin
        if (q.size() == 0) chk("underflow", 32'd1, 32'd0);
        else chk("m_data", {24'd0, m_data}, {24'd0, q.pop_front()});
        exp_cnt++;
      end
      if (flush) q.delete();
      else if (s_valid && s_ready) q.push_back(s_data);
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    bit fired;
    int acc;
    int budget;

    // Reset state
    do_reset();
    chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_data", {24'd0, m_data}, 32'd0);
    chk("rst_occ", {30'd0, occ}, 32'd0);
    chk("rst_beat_cnt", {16'd0, beat_cnt}, 32'd0);
    mon_en = 1'b1;

    // Full-rate streaming
    m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      s_valid = 1'b1; s_data = 8'(i);
      cyc();
      chk("stream_data", {24'd0, m_data}, i);
      chk("stream_sready", {31'd0, s_ready}, 32'd1);
    end
    s_valid = 1'b0;
    cyc();
    cyc();
    chk("stream_cnt", {16'd0, beat_cnt}, 32'd16);
    chk("stream_cnt4", {28'd0, beat_cnt4}, 32'd0);

    // Backpressure into the skid entry
    s_valid = 1'b1; s_data = 8'h20; m_ready = 1'b1;
    cyc();
    s_data = 8'h21; m_ready = 1'b0;
    cyc();
    chk("bp_occ", {30'd0, occ}, 32'd2);
    chk("bp_sready", {31'd0, s_ready}, 32'd0);
    chk("bp_mdata", {24'd0, m_data}, 32'h20);
    s_data = 8'h22;
    cyc();
    chk("bp_hold_mdata", {24'd0, m_data}, 32'h20);
    m_ready = 1'b1;
    cyc();
    chk("bp_out21", {24'd0, m_data}, 32'h21);
    cyc();
    chk("bp_out22", {24'd0, m_data}, 32'h22);
    s_valid = 1'b0;
    cyc();
    chk("bp_drained", {30'd0, occ}, 32'd0);

    // Random stalls on both sides
    acc = 0; budget = 0;
    s_valid = 1'b0;
    while (acc < 1000 && budget < 10000) begin
      @(negedge clk);
      fired = s_valid && s_ready;
      if (fired) acc++;
      @(posedge clk);
      #1;
      budget++;
      if (!s_valid || fired) begin
        s_valid = ($urandom_range(0, 99) >= 30) && (acc < 1000);
        s_data  = 8'($urandom);
      end
      m_ready = ($urandom_range(0, 99) >= 30);
    end
    chk("rand_budget", {31'd0, acc >= 1000}, 32'd1);
    s_valid = 1'b0; m_ready = 1'b1;
    repeat (4) cyc();
    chk("rand_drain", q.size(), 32'd0);
    chk("rand_cnt", {16'd0, beat_cnt}, exp_cnt);
    chk("rand_cnt4", {28'd0, beat_cnt4}, exp_cnt % 16);

    // Flush while full; 0xCC must be discarded
    m_ready = 1'b0; s_valid = 1'b1; s_data = 8'hAA;
    cyc();
    s_data = 8'hBB;
    cyc();
    chk("fl_full", {30'd0, occ}, 32'd2);
    s_data = 8'hCC; flush = 1'b1;
    cyc();
    flush = 1'b0; s_valid = 1'b0;
    chk("fl_occ", {30'd0, occ}, 32'd0);
    chk("fl_mvalid", {31'd0, m_valid}, 32'd0);
    chk("fl_sready", {31'd0, s_ready}, 32'd1);
    m_ready = 1'b1;
    repeat (3) cyc();

    // Flush in ONE: delivered beat still counts, accepted beat discarded
    m_ready = 1'b0; s_valid = 1'b1; s_data = 8'hDD;
    cyc();
    s_data = 8'hCC; m_ready = 1'b1; flush = 1'b1;
    cyc();
    flush = 1'b0; s_valid = 1'b0;
    chk("fl1_occ", {30'd0, occ}, 32'd0);
    chk("fl1_cnt", {16'd0, beat_cnt}, exp_cnt);
    repeat (3) cyc();

    // Counter wrap on the 4-bit instance
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      s_valid = 1'b1; s_data = 8'(8'h40 + i);
      cyc();
    end
    s_valid = 1'b0;
    cyc();
    cyc();
    chk("wrap_cnt4", {28'd0, beat_cnt4}, 32'd1);
    chk("wrap_cnt16", {16'd0, beat_cnt}, 32'd17);

    // Asynchronous reset while full
    m_ready = 1'b0; s_valid = 1'b1; s_data = 8'h51;
    cyc();
    s_data = 8'h52;
    cyc();
    chk("ar_full", {30'd0, occ}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_mvalid", {31'd0, m_valid}, 32'd0);
    chk("ar_occ", {30'd0, occ}, 32'd0);
    chk("ar_sready", {31'd0, s_ready}, 32'd1);
    s_valid = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (2) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
